// File: rtl/avalon_mm_arb2.sv
// 2:1 round-robin arbiter sharing one pipelined Avalon-MM master between two requesters,
// with an ID FIFO routing in-order read responses back. Define ARB_STATS_EN for command/FIFO statistics.
module avalon_mm_arb2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int MAX_OUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] s0_address,
  input  logic              s0_read,
  input  logic              s0_write,
  input  logic [DATA_W-1:0] s0_writedata,
  output logic              s0_waitrequest,
  output logic [DATA_W-1:0] s0_readdata,
  output logic              s0_readdatavalid,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic              s1_waitrequest,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              err_unexp
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]                  stat_cmd0,
  output logic [31:0]                  stat_cmd1,
  output logic [$clog2(MAX_OUT):0]     stat_fifo_max
`endif
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_writedata_q, m_writedata_d;
  logic                m_read_q, m_read_d;
  logic                m_write_q, m_write_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [MAX_OUT-1:0]  fifo_mem_q, fifo_mem_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_unexp_q, err_unexp_d;

  logic fifo_full, elig0, elig1, sel, accept, push, pop, head_id;

  assign fifo_full = (count_q == FULL_CNT);
  assign elig0     = s0_write | (s0_read & ~fifo_full);
  assign elig1     = s1_write | (s1_read & ~fifo_full);
  assign sel       = (elig0 && elig1) ? ~last_grant_q : elig1;
  assign accept    = (state_q == BUSY) && !m_waitrequest;
  assign push      = accept && m_read_q;
  assign pop       = m_readdatavalid && (count_q != '0);
  assign head_id   = fifo_mem_q[rd_ptr_q];

  // Arbitration and command-holding FSM; m_* only change on grant or on acceptance.
  always_comb begin
    state_d       = state_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    m_read_d      = m_read_q;
    m_write_d     = m_write_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d       = sel;
          last_grant_d  = sel;
          state_d       = BUSY;
          m_address_d   = sel ? s1_address : s0_address;
          m_writedata_d = sel ? s1_writedata : s0_writedata;
          m_write_d     = sel ? s1_write : s0_write;
          m_read_d      = sel ? (s1_read & ~s1_write) : (s0_read & ~s0_write);
        end
      end
      BUSY: begin
        if (!m_waitrequest) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ID FIFO: one bit per outstanding read naming the port that issued it.
  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_unexp_d = err_unexp_q | (m_readdatavalid && (count_q == '0));
    if (push) begin
      fifo_mem_d[wr_ptr_q] = grant_q;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      fifo_mem_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_unexp_q   <= err_unexp_d;
    end
  end

  assign m_address        = m_address_q;
  assign m_writedata      = m_writedata_q;
  assign m_read           = m_read_q;
  assign m_write          = m_write_q;
  assign err_unexp        = err_unexp_q;
  assign s0_waitrequest   = ~(accept && !grant_q);
  assign s1_waitrequest   = ~(accept && grant_q);
  assign s0_readdata      = m_readdata;
  assign s1_readdata      = m_readdata;
  assign s0_readdatavalid = pop && !head_id;
  assign s1_readdatavalid = pop && head_id;

`ifdef ARB_STATS_EN
  logic [31:0]      stat_cmd0_q, stat_cmd0_d;
  logic [31:0]      stat_cmd1_q, stat_cmd1_d;
  logic [CNT_W-1:0] stat_fifo_max_q, stat_fifo_max_d;

  // Per-port accept counters wrap naturally; high-water mark tracks the next FIFO count.
  always_comb begin
    stat_cmd0_d     = stat_cmd0_q;
    stat_cmd1_d     = stat_cmd1_q;
    stat_fifo_max_d = stat_fifo_max_q;
    if (accept && !grant_q) stat_cmd0_d = stat_cmd0_q + 32'd1;
    if (accept && grant_q)  stat_cmd1_d = stat_cmd1_q + 32'd1;
    if (count_d > stat_fifo_max_q) stat_fifo_max_d = count_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cmd0_q     <= '0;
      stat_cmd1_q     <= '0;
      stat_fifo_max_q <= '0;
    end else begin
      stat_cmd0_q     <= stat_cmd0_d;
      stat_cmd1_q     <= stat_cmd1_d;
      stat_fifo_max_q <= stat_fifo_max_d;
    end
  end

  assign stat_cmd0     = stat_cmd0_q;
  assign stat_cmd1     = stat_cmd1_q;
  assign stat_fifo_max = stat_fifo_max_q;
`endif

endmodule

// File: tb/tb_avalon_mm_arb2.sv
// Directed self-checking bench for avalon_mm_arb2: reset, single read, round robin,
// stall, FIFO-full back-pressure, response routing and spurious-response flagging.
module tb_avalon_mm_arb2;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 256;
  localparam int MAX_OUT = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] s0_address, s1_address, m_address;
  logic              s0_read, s0_write, s1_read, s1_write;
  logic [DATA_W-1:0] s0_writedata, s1_writedata, m_writedata;
  logic              s0_waitrequest, s1_waitrequest;
  logic [DATA_W-1:0] s0_readdata, s1_readdata, m_readdata;
  logic              s0_readdatavalid, s1_readdatavalid;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic              err_unexp;
`ifdef ARB_STATS_EN
  logic [31:0]              stat_cmd0, stat_cmd1;
  logic [$clog2(MAX_OUT):0] stat_fifo_max;
`endif

  localparam logic [DATA_W-1:0] WD0 = {8{32'hD0D0_0000}};
  localparam logic [DATA_W-1:0] WD1 = {8{32'hD1D1_1111}};

  int checks = 0;
  int passes = 0;

  avalon_mm_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_waitrequest(s0_waitrequest),
    .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_waitrequest(s1_waitrequest),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .err_unexp(err_unexp)
`ifdef ARB_STATS_EN
    , .stat_cmd0(stat_cmd0), .stat_cmd1(stat_cmd1), .stat_fifo_max(stat_fifo_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    else
      passes++;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                               input logic r1, input logic w1, input logic [ADDR_W-1:0] a1);
    s0_read = r0; s0_write = w0; s0_address = a0;
    s1_read = r1; s1_write = w1; s1_address = a1;
  endtask

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 0, '0, 0, 0, '0);
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b0;
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    int seen;
    int issued;
    logic bump;
    logic [ADDR_W-1:0] addr;

    reset = 1'b1;
    applyStimulus(0, 0, '0, 0, 0, '0);
    s0_writedata = WD0; s1_writedata = WD1;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    #12;
    checkOutput("rst_m_read", m_read, 0);
    checkOutput("rst_m_write", m_write, 0);
    checkOutput("rst_s0_wait", s0_waitrequest, 1);
    checkOutput("rst_s1_wait", s1_waitrequest, 1);
    checkOutput("rst_err", err_unexp, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Single read from port 0
    applyStimulus(1, 0, 32'h100, 0, 0, '0);
    #1 checkOutput("rd_s0_wait_idle", s0_waitrequest, 1);
    nextCycle(); #1;
    checkOutput("rd_m_read", m_read, 1);
    checkOutput("rd_addr", m_address, 32'h100);
    checkOutput("rd_s0_wait", s0_waitrequest, 0);
    checkOutput("rd_s1_wait", s1_waitrequest, 1);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, '0);
    #1 checkOutput("rd_m_read_drop", m_read, 0);
    repeat (3) nextCycle();
    m_readdata = {32{8'hA5}}; m_readdatavalid = 1'b1;
    #1;
    checkOutput("rd_s0_rdv", s0_readdatavalid, 1);
    checkOutput("rd_s0_data", s0_readdata, {32{8'hA5}});
    checkOutput("rd_s1_rdv", s1_readdatavalid, 0);
    nextCycle();
    m_readdatavalid = 1'b0;
    #1 checkOutput("rd_no_err", err_unexp, 0);

    // Round robin on continuous writes, port 0 wins the first tie after reset
    doReset();
    applyStimulus(0, 1, 32'h200, 0, 1, 32'h300);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      nextCycle(); #1;
      if (m_write) begin
        if (seen < 6) begin
          checkOutput("rr_addr", m_address, (seen % 2 == 0) ? 32'h200 : 32'h300);
          checkOutput("rr_data", m_writedata, (seen % 2 == 0) ? WD0 : WD1);
        end
        seen++;
      end
    end
    checkOutput("rr_count", seen, 6);
    applyStimulus(0, 0, '0, 0, 0, '0);
`ifdef ARB_STATS_EN
    checkOutput("stat_cmd0", stat_cmd0, 3);
    checkOutput("stat_cmd1", stat_cmd1, 3);
`endif

    // Downstream stall on a port-1 write; port 0 read arrives meanwhile
    m_waitrequest = 1'b1;
    applyStimulus(0, 0, '0, 0, 1, 32'h400);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      if (c == 2) applyStimulus(1, 0, 32'h500, 0, 1, 32'h400);
      #1;
      checkOutput("stall_m_write", m_write, 1);
      checkOutput("stall_addr", m_address, 32'h400);
      checkOutput("stall_s1_wait", s1_waitrequest, 1);
      checkOutput("stall_s0_wait", s0_waitrequest, 1);
    end
    nextCycle();
    m_waitrequest = 1'b0;
    #1;
    checkOutput("stall_s1_acc", s1_waitrequest, 0);
    checkOutput("stall_addr_acc", m_address, 32'h400);
    checkOutput("stall_s0_hold", s0_waitrequest, 1);
    nextCycle();
    applyStimulus(1, 0, 32'h500, 0, 0, '0);
    #1;
    checkOutput("stall_idle_wr", m_write, 0);
    checkOutput("stall_idle_rd", m_read, 0);
    nextCycle(); #1;
    checkOutput("stall_s0_rd", m_read, 1);
    checkOutput("stall_s0_addr", m_address, 32'h500);
    checkOutput("stall_s0_acc", s0_waitrequest, 0);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, '0);
    nextCycle();
    m_readdata = {32{8'h3C}}; m_readdatavalid = 1'b1;
    #1;
    checkOutput("stall_rsp_s0", s0_readdatavalid, 1);
    checkOutput("stall_rsp_s1", s1_readdatavalid, 0);
    nextCycle();
    m_readdatavalid = 1'b0;

    // Fill the ID FIFO with port-0 reads, no responses
    addr = 32'h600; issued = 0; bump = 1'b0;
    applyStimulus(1, 0, addr, 0, 0, '0);
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      if (bump) begin
        addr = addr + 32'd1;
        applyStimulus(1, 0, addr, 0, 0, '0);
        bump = 1'b0;
      end
      #1;
      if (m_read && !s0_waitrequest) begin
        checkOutput("full_addr", m_address, 32'h600 + 32'(issued));
        issued++;
        bump = 1'b1;
      end
    end
    checkOutput("full_issued", issued, 8);
    checkOutput("full_blocked", m_read, 0);
    applyStimulus(1, 0, addr, 0, 1, 32'h700);
    nextCycle(); #1;
    checkOutput("full_s1_write", m_write, 1);
    checkOutput("full_s1_addr", m_address, 32'h700);
    checkOutput("full_s1_acc", s1_waitrequest, 0);
    nextCycle();
    applyStimulus(1, 0, addr, 0, 0, '0);
    m_readdata = {32{8'h11}}; m_readdatavalid = 1'b1;
    #1;
    checkOutput("full_rsp_s0", s0_readdatavalid, 1);
    checkOutput("full_pop_noissue", m_read, 0);
    nextCycle();
    m_readdatavalid = 1'b0;
    #1 checkOutput("full_still_blocked", m_read, 0);
    nextCycle(); #1;
    checkOutput("full_ninth_rd", m_read, 1);
    checkOutput("full_ninth_addr", m_address, 32'h608);
    nextCycle();
    applyStimulus(0, 0, '0, 0, 0, '0);
`ifdef ARB_STATS_EN
    checkOutput("stat_fifo_max", stat_fifo_max, 8);
`endif
    m_readdatavalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("drain_s0", s0_readdatavalid, 1);
      checkOutput("drain_s1", s1_readdatavalid, 0);
      nextCycle();
    end
    m_readdatavalid = 1'b0;

    // Interleaved reads: port 0 was granted last, so port 1 goes first
    applyStimulus(1, 0, 32'h800, 1, 0, 32'h900);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      nextCycle(); #1;
      if (m_read) begin
        if (seen < 4) checkOutput("il_addr", m_address, (seen % 2 == 0) ? 32'h900 : 32'h800);
        seen++;
      end
    end
    checkOutput("il_count", seen, 4);
    applyStimulus(0, 0, '0, 0, 0, '0);
    m_readdatavalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_readdata = {32{8'(8'h50 + k)}};
      #1;
      checkOutput("il_rdv_s1", s1_readdatavalid, (k % 2 == 0) ? 1 : 0);
      checkOutput("il_rdv_s0", s0_readdatavalid, (k % 2 == 0) ? 0 : 1);
      checkOutput("il_data", (k % 2 == 0) ? s1_readdata : s0_readdata, {32{8'(8'h50 + k)}});
      nextCycle();
    end
    m_readdatavalid = 1'b0;

    // Spurious response with the FIFO empty
    nextCycle();
    m_readdatavalid = 1'b1;
    #1;
    checkOutput("sp_s0_rdv", s0_readdatavalid, 0);
    checkOutput("sp_s1_rdv", s1_readdatavalid, 0);
    checkOutput("sp_err_before", err_unexp, 0);
    nextCycle();
    m_readdatavalid = 1'b0;
    #1 checkOutput("sp_err_set", err_unexp, 1);
    repeat (3) nextCycle();
    #1 checkOutput("sp_err_sticky", err_unexp, 1);

    // Reset while BUSY with one read outstanding
    nextCycle();
    applyStimulus(0, 0, '0, 1, 0, 32'hA00);
    nextCycle();
    nextCycle();
    applyStimulus(1, 0, 32'hB00, 0, 0, '0);
    m_waitrequest = 1'b1;
    nextCycle(); #1;
    checkOutput("mr_busy", m_read, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("mr_m_read", m_read, 0);
    checkOutput("mr_addr", m_address, 0);
    checkOutput("mr_s0_wait", s0_waitrequest, 1);
    checkOutput("mr_s1_wait", s1_waitrequest, 1);
    checkOutput("mr_err", err_unexp, 0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 0, '0, 0, 0, '0);
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b1;
    #1;
    checkOutput("mr_late_s0", s0_readdatavalid, 0);
    checkOutput("mr_late_s1", s1_readdatavalid, 0);
    nextCycle();
    m_readdatavalid = 1'b0;
    #1 checkOutput("mr_late_err", err_unexp, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
